tc_seq: RTL and testbench
=========================

# tc_seq

Parametrised, multi-cycle two's-complement unit. Takes one WIDTH-bit operand per transaction and returns pass-through, negation or absolute value. It works CHUNK bits per clock, LSB chunk first, and keeps a registered carry between chunks. It sits between an operand producer and a result consumer, and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be at least 2.
- CHUNK, 4, bits processed per CALC cycle; WIDTH % CHUNK must be 0. NCH = WIDTH/CHUNK is the number of chunks.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand/mode valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- operand  in  WIDTH  two's-complement input; sampled on the accept edge.
- mode  in  2  00 pass, 01 negate, 10 absolute value, 11 reserved (behaves as pass). Sampled on the accept edge.
- out_valid  out  1  result/ovf valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- ovf  out  1  set when a negation was required and the operand is the most negative value (1 followed by WIDTH-1 zeros).

## Operation
- States: IDLE, CALC, DONE. Registers: op_q, inv_q, carry_q, chunk counter cnt (range 0..NCH-1), result, ovf.
- IDLE:
  - in_ready = 1.
  - On in_valid high: latch op_q = operand.
  - Set inv_q = (mode==01) | (mode==10 & operand[WIDTH-1]).
  - Set carry_q = inv_q and cnt = 0.
  - Set ovf = inv_q & (operand == {1, zeros}).
  - Go to CALC.
- CALC, each cycle:
  - sum = (op_q chunk[cnt] XOR {CHUNK{inv_q}}) + carry_q, computed at CHUNK+1 bits.
  - result chunk[cnt] = sum[CHUNK-1:0]; carry_q = sum[CHUNK].
  - cnt increments. When cnt == NCH-1, go to DONE instead of incrementing.
- Chunk arithmetic is an invert plus an increment rippled across chunks. The final carry-out is discarded (modulo 2^WIDTH).
- The most negative operand under negate or abs returns the operand unchanged, with ovf = 1.
- DONE: out_valid = 1; result and ovf held stable. On out_ready high, go to IDLE.
- in_ready = 0 in CALC and DONE. in_valid is ignored there; no operand is captured.
- out_valid = 0 in IDLE and CALC.
- Mode 11 behaves exactly as pass: inv_q = 0, ovf = 0.
- NCH = 1 is legal: CALC lasts one cycle.
- Result chunks not yet written in CALC keep their previous values. Consumers only sample under out_valid.

## Timing
- Reset (rst_n low, any state, asynchronous):
  - State goes to IDLE.
  - result = 0, ovf = 0, out_valid = 0, cnt = 0, carry_q = 0, op_q = 0, inv_q = 0.
  - in_ready = 1 while and after reset.
- Reset in mid-CALC or in DONE aborts the transaction. No output is produced for it.
- Accept edge E0 is the first rising edge with IDLE & in_valid.
- Chunk i is written at edge E(i+1). The DONE transition happens at edge E(NCH).
- out_valid is high in the cycle after E(NCH), i.e. NCH cycles after the accept edge.
- Result handover happens on the first edge with DONE & out_ready. If out_ready is already high, DONE lasts exactly one cycle.
- Minimum transaction period is NCH+2 cycles: 1 IDLE, NCH CALC, 1 DONE.
- Under backpressure (out_ready low), DONE holds indefinitely with result/ovf constant and in_ready = 0.
- in_ready and out_valid are decoded directly from registered state. There is no combinational path from in_valid or out_ready to any output.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless noted.
- Negate 0x0001 with out_ready=1 → out_valid high 4 cycles after accept, result=0xFFFF, ovf=0, in_ready high again the following cycle.
- Negate 0x8000 → result=0x8000, ovf=1. Abs 0x8000 → result=0x8000, ovf=1.
- Abs 0xFFF6 → 0x000A, ovf=0. Abs 0x0005 → 0x0005. Negate 0x0000 → 0x0000, ovf=0 (carry ripples through all 4 chunks).
- Pass 0x1234 and mode 11 with 0xBEEF → result equals operand, ovf=0.
- Backpressure: hold out_ready low 10 cycles after DONE while driving in_valid with new operands → result/ovf constant, in_ready=0, no capture. Release out_ready → next operand accepted one cycle later.
- Assert rst_n low during the second CALC cycle → all outputs zero, no out_valid. Then run negate 0x00F0 → 0xFF10.
- Also rerun negate 0x0001 with WIDTH=8, CHUNK=8 → 0xFF after 1 CALC cycle.

Source files
------------

// File: rtl/tc_seq.sv
// tc_seq: chunk-serial two's-complement pass/negate/abs unit, LSB chunk first with a registered carry.
// Latency: out_valid NCH cycles after accept; DONE holds result/ovf until out_ready; in_ready only in IDLE.
module tc_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(NCH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CMASK    = WIDTH'({CHUNK{1'b1}});

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_chk
    $error("tc_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  op_q, op_d;
  logic              inv_q, inv_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              ovf_q, ovf_d;

  logic [CHUNK-1:0]  chunk_in;
  logic [CHUNK:0]    sum;
  int                sh;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    inv_d    = inv_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    sh       = int'(cnt_q) * CHUNK;
    chunk_in = CHUNK'(op_q >> sh);
    // Conditional invert plus the carry that was seeded with inv_q gives the +1 of negation.
    sum      = {1'b0, chunk_in ^ {CHUNK{inv_q}}} + {{CHUNK{1'b0}}, carry_q};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = operand;
          inv_d   = (mode == 2'b01) || ((mode == 2'b10) && operand[WIDTH-1]);
          carry_d = inv_d;
          cnt_d   = '0;
          ovf_d   = inv_d && (operand == MOST_NEG);
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = (res_q & ~(CMASK << sh)) | (WIDTH'(sum[CHUNK-1:0]) << sh);
        carry_d = sum[CHUNK];
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      inv_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      inv_q   <= inv_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_tc_seq.sv
// Scoreboard bench for tc_seq: 16/4 main instance plus an 8/8 single-chunk instance.
module tb_tc_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [15:0] operand, result;
  logic [1:0]  mode;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, ovf8;
  logic [7:0]  operand8, result8;
  logic [1:0]  mode8;

  tc_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .operand(operand), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
  );

  tc_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .operand(operand8), .mode(mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [15:0] op;
    logic [1:0]  md;
    logic [15:0] res;
    logic        ovf;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  function automatic logic [16:0] model(input logic [15:0] op, input logic [1:0] md);
    logic inv;
    logic [15:0] r;
    inv = (md == 2'b01) || ((md == 2'b10) && op[15]);
    r   = inv ? (16'd0 - op) : op;
    return {inv && (op == 16'h8000), r};
  endfunction

  // Drive one operand for a single cycle; caller ensures in_ready is high.
  task automatic send(input logic [15:0] op, input logic [1:0] md);
    in_valid = 1'b1;
    operand  = op;
    mode     = md;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset16: in_ready=%b out_valid=%b result=%h ovf=%b, want 1 0 0000 0",
               in_ready, out_valid, result, ovf);
    end
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || result8 !== 8'h0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: in_ready=%b out_valid=%b result=%h ovf=%b, want 1 0 00 0",
               in_ready8, out_valid8, result8, ovf8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    vec_t vecs[8];
    logic [16:0] e;
    int n;
    vecs = '{
      '{16'h0001, 2'b01, 16'hFFFF, 1'b0},
      '{16'h8000, 2'b01, 16'h8000, 1'b1},
      '{16'h8000, 2'b10, 16'h8000, 1'b1},
      '{16'hFFF6, 2'b10, 16'h000A, 1'b0},
      '{16'h0005, 2'b10, 16'h0005, 1'b0},
      '{16'h0000, 2'b01, 16'h0000, 1'b0},
      '{16'h1234, 2'b00, 16'h1234, 1'b0},
      '{16'hBEEF, 2'b11, 16'hBEEF, 1'b0}
    };
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].ovf, vecs[i].res});
      send(vecs[i].op, vecs[i].md);
      wait_out(n);
      e = exp_q.pop_front();
      checks++;
      if (n != 4) begin
        errors++;
        $display("FAIL latency vec%0d: out_valid after %0d cycles, want 4", i, n);
      end
      checks++;
      if ({ovf, result} !== e) begin
        errors++;
        $display("FAIL result vec%0d: ovf=%b result=%h, want ovf=%b result=%h",
                 i, ovf, result, e[16], e[15:0]);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL handover vec%0d: in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] op;
    logic [1:0]  md;
    logic [16:0] e;
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op = (i == 5) ? 16'h8000 : 16'($urandom);
      md = 2'($urandom_range(0, 3));
      exp_q.push_back(model(op, md));
      send(op, md);
      wait_out(n);
      e = exp_q.pop_front();
      checks++;
      if (n != 4 || {ovf, result} !== e) begin
        errors++;
        $display("FAIL b2b%0d op=%h md=%b: cycles=%0d ovf=%b result=%h, want 4 ovf=%b result=%h",
                 i, op, md, n, ovf, result, e[16], e[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [16:0] e;
    int n;
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 16'hFFFD});
    send(16'h0003, 2'b01);
    wait_out(n);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {ovf, result} !== e) begin
      errors++;
      $display("FAIL bp_first: out_valid=%b ovf=%b result=%h, want 1 ovf=%b result=%h",
               out_valid, ovf, result, e[16], e[15:0]);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      operand  = 16'($urandom) | 16'h0100;
      mode     = 2'b01;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'hFFFD || ovf !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b result=%h ovf=%b, want 1 0 fffd 0",
                 i, out_valid, in_ready, result, ovf);
      end
    end
    operand   = 16'h0010;
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 16'hFFF0});
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: in_ready=%b, want 0", in_ready);
    end
    wait_out(n);
    e = exp_q.pop_front();
    checks++;
    if (n != 4 || {ovf, result} !== e) begin
      errors++;
      $display("FAIL bp_next: cycles=%0d ovf=%b result=%h, want 4 ovf=%b result=%h",
               n, ovf, result, e[16], e[15:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc;
    logic [16:0] e;
    int n;
    int seen;
    out_ready = 1'b1;
    send(16'h1234, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (result !== 16'h0 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: result=%h ovf=%b out_valid=%b in_ready=%b, want 0000 0 0 1",
               result, ovf, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort: out_valid seen %0d cycles after aborted txn, want 0", seen);
    end
    exp_q.push_back({1'b0, 16'hFF10});
    send(16'h00F0, 2'b01);
    wait_out(n);
    e = exp_q.pop_front();
    checks++;
    if (n != 4 || {ovf, result} !== e) begin
      errors++;
      $display("FAIL post_reset: cycles=%0d ovf=%b result=%h, want 4 ovf=%b result=%h",
               n, ovf, result, e[16], e[15:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width8;
    logic [16:0] e;
    int n;
    out_ready8 = 1'b1;
    exp_q.push_back({1'b0, 8'h00, 8'hFF});
    in_valid8 = 1'b1;
    operand8  = 8'h01;
    mode8     = 2'b01;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (n != 1 || {ovf8, 8'h00, result8} !== e) begin
      errors++;
      $display("FAIL width8: cycles=%0d ovf=%b result=%h, want 1 ovf=%b result=%h",
               n, ovf8, result8, e[16], e[7:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL width8_handover: in_ready=%b out_valid=%b, want 1 0", in_ready8, out_valid8);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    operand    = '0;
    mode       = '0;
    out_ready  = 1'b1;
    in_valid8  = 1'b0;
    operand8   = '0;
    mode8      = '0;
    out_ready8 = 1'b1;

    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_calc();
    test_width8();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
